// File: rtl/data_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mem_pkg
// Brief    : Shared state encoding and constants for the data-memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RSP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = IDLE,
      S_REQ  = REQ,
      S_RSP  = RSP,
      S_DONE = DONE
   } state_t;

   localparam logic [31:0] ERR_RDATA  = 32'h0;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) == 2'b00;
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge_if
// Brief    : Valid/ready request and response bus to the external memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_we;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [DATA_W-1:0] mem_req_wdata;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface
`default_nettype wire

// File: rtl/data_mem_bridge_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bridge_timeout_cnt
// Brief    : Counts enabled cycles and flags the TIMEOUT-th one.
// Revision : 1.0 - initial release
// ============================================================================
module bridge_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clear,
   input  wire logic enable,
   output logic      expired
);
   localparam int               CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   // Fires on the last allowed cycle so REQ+RSP never exceeds TIMEOUT cycles.
   assign expired = enable && (cnt == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bridge
// Brief    : Turns single-cycle core loads/stores into stalled bus transactions.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_bridge
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  wire logic              CLK,
   input  wire logic              RESET,
   input  wire logic              MemRead,
   input  wire logic              MemWrite,
   input  wire logic [ADDR_W-1:0] Address,
   input  wire logic [DATA_W-1:0] Write_data,
   output logic      [DATA_W-1:0] Read_data,
   output logic                   Stall,
   output logic                   Mem_error,
   data_mem_bridge_if.master      mem
);
   state_t state;
   logic   acc;
   logic   legal;
   logic   go_req;
   logic   handshake;
   logic   cnt_en;
   logic   expired;

   assign acc       = MemRead | MemWrite;
   assign legal     = is_aligned(Address[1:0]) && !(MemRead && MemWrite);
   assign go_req    = (state == S_IDLE) && acc && legal;
   assign handshake = mem.mem_req_valid && mem.mem_req_ready;
   assign cnt_en    = (state == S_REQ) || (state == S_RSP);

   // DONE is the single commit cycle; IDLE stalls as soon as an access appears.
   assign Stall = (state == S_IDLE) ? acc : (state != S_DONE);

   bridge_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (CLK),
      .rst     (RESET),
      .clear   (go_req),
      .enable  (cnt_en),
      .expired (expired)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state             <= S_IDLE;
         Read_data         <= '0;
         Mem_error         <= 1'b0;
         mem.mem_req_valid <= 1'b0;
         mem.mem_req_we    <= 1'b0;
         mem.mem_req_addr  <= '0;
         mem.mem_req_wdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (acc) begin
                  if (legal) begin
                     mem.mem_req_valid <= 1'b1;
                     mem.mem_req_we    <= MemWrite;
                     mem.mem_req_addr  <= Address & ~ADDR_W'(ALIGN_MASK);
                     mem.mem_req_wdata <= Write_data;
                     state             <= S_REQ;
                  end else begin
                     Mem_error <= 1'b1;
                     Read_data <= DATA_W'(ERR_RDATA);
                     state     <= S_DONE;
                  end
               end
            end
            S_REQ: begin
               if (expired) begin
                  Mem_error         <= 1'b1;
                  Read_data         <= DATA_W'(ERR_RDATA);
                  mem.mem_req_valid <= 1'b0;
                  state             <= S_DONE;
               end else if (handshake) begin
                  mem.mem_req_valid <= 1'b0;
                  state             <= mem.mem_req_we ? S_DONE : S_RSP;
               end
            end
            S_RSP: begin
               if (expired) begin
                  Mem_error <= 1'b1;
                  Read_data <= DATA_W'(ERR_RDATA);
                  state     <= S_DONE;
               end else if (mem.mem_rsp_valid) begin
                  Read_data <= mem.mem_rsp_rdata;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_bridge
// Brief    : Directed and randomized checks of the bridge against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_bridge;
   localparam int TO = 8;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        MemRead, MemWrite;
   logic [31:0] Address, Write_data;
   logic [31:0] Read_data;
   logic        Stall, Mem_error;

   data_mem_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .Stall      (Stall),
      .Mem_error  (Mem_error),
      .mem        (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ext_mem [logic [31:0]];
   logic [31:0] last_rd;
   logic        err_exp;

   int          r_stalls;
   logic        r_saw_valid, r_stable, r_done, r_we;
   logic [31:0] r_addr, r_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ext_rd(input logic [31:0] a);
      return ext_mem.exists(a) ? ext_mem[a] : 32'h0;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   // Plays core and external memory cycle by cycle until the core is released.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                         input logic give_rsp, input logic rst_in_rsp);
      int   rdy_cnt  = 0;
      int   rsp_cnt  = 0;
      logic hs       = 1'b0;
      logic rsp_sent = 1'b0;
      r_stalls = 0; r_saw_valid = 1'b0; r_stable = 1'b1; r_done = 1'b0; r_we = 1'b0;
      r_addr = '0; r_wdata = '0;
      @(negedge CLK);
      MemRead = rd; MemWrite = wr; Address = addr; Write_data = wdata;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
      for (int c = 0; c < 40 && !r_done; c++) begin
         #1;
         if (!Stall) begin
            r_done = 1'b1;
            MemRead = 1'b0; MemWrite = 1'b0;
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
         end else begin
            r_stalls++;
            bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0;
            if (bus.mem_req_valid) begin
               if (!r_saw_valid) begin
                  r_saw_valid = 1'b1;
                  r_addr = bus.mem_req_addr; r_we = bus.mem_req_we; r_wdata = bus.mem_req_wdata;
               end else if ({bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata} !==
                            {r_addr, r_we, r_wdata}) begin
                  r_stable = 1'b0;
               end
               if (rdy_cnt == rdy_dly) begin
                  bus.mem_req_ready = 1'b1;
                  hs = 1'b1;
                  if (bus.mem_req_we) ext_mem[bus.mem_req_addr] = bus.mem_req_wdata;
               end
               rdy_cnt++;
            end else if (hs && !r_we) begin
               if (rst_in_rsp) begin
                  MemRead = 1'b0;
                  #1 RESET = 1'b1;
                  #1;
                  chk("rst_async_read_data", Read_data, 32'h0);
                  chk("rst_async_mem_error", 32'(Mem_error), 32'd0);
                  chk("rst_async_req_valid", 32'(bus.mem_req_valid), 32'd0);
                  chk("rst_async_req_addr", bus.mem_req_addr, 32'h0);
                  chk("rst_async_stall", 32'(Stall), 32'd0);
                  #1 RESET = 1'b0;
                  r_done = 1'b1;
               end else if (give_rsp && !rsp_sent) begin
                  if (rsp_cnt == rsp_dly) begin
                     bus.mem_rsp_valid = 1'b1;
                     bus.mem_rsp_rdata = ext_rd(r_addr);
                     rsp_sent = 1'b1;
                  end
                  rsp_cnt++;
               end
            end
            if (!r_done) @(negedge CLK);
         end
      end
      chk("access_completes", 32'(r_done), 32'd1);
   endtask

   // Predicts the outcome of one access from the bridge's externally visible rules.
   task automatic checked_op(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int rdy_dly, input int rsp_dly, input logic give_rsp);
      logic legal;
      int   exp_stalls;
      legal = (addr[1:0] == 2'b00) && !(rd && wr);
      if (!legal) begin
         exp_stalls = 1; last_rd = 32'h0; err_exp = 1'b1;
      end else if (wr) begin
         exp_stalls = 2 + rdy_dly; ref_mem[addr] = wdata;
      end else if (give_rsp) begin
         exp_stalls = 3 + rdy_dly + rsp_dly; last_rd = ref_rd(addr);
      end else begin
         exp_stalls = 1 + TO; last_rd = 32'h0; err_exp = 1'b1;
      end
      access(rd, wr, addr, wdata, rdy_dly, rsp_dly, give_rsp, 1'b0);
      chk({tag, "_stalls"}, 32'(r_stalls), 32'(exp_stalls));
      chk({tag, "_read_data"}, Read_data, last_rd);
      chk({tag, "_mem_error"}, 32'(Mem_error), 32'(err_exp));
      chk({tag, "_bus_used"}, 32'(r_saw_valid), 32'(legal));
      if (legal) begin
         chk({tag, "_bus_addr"}, r_addr, {addr[31:2], 2'b00});
         chk({tag, "_bus_we"}, 32'(r_we), 32'(wr));
         chk({tag, "_bus_stable"}, 32'(r_stable), 32'd1);
         if (wr) chk({tag, "_bus_wdata"}, r_wdata, wdata);
      end
   endtask

   initial begin
      RESET = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; Write_data = '0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_rdata = '0;
      last_rd = 32'h0; err_exp = 1'b0;
      ext_mem[32'h40] = 32'h1234_5678; ref_mem[32'h40] = 32'h1234_5678;

      #12;
      chk("reset_read_data", Read_data, 32'h0);
      chk("reset_mem_error", 32'(Mem_error), 32'd0);
      chk("reset_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("reset_req_we", 32'(bus.mem_req_we), 32'd0);
      chk("reset_req_addr", bus.mem_req_addr, 32'h0);
      chk("reset_req_wdata", bus.mem_req_wdata, 32'h0);
      chk("reset_stall", 32'(Stall), 32'd0);
      @(negedge CLK);
      RESET = 1'b0;

      checked_op("load_fast", 1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b1);
      checked_op("store_slow", 1'b0, 1'b1, 32'h100, 32'hCAFE_F00D, 4, 0, 1'b1);
      checked_op("load_back", 1'b1, 1'b0, 32'h100, 32'h0, 1, 2, 1'b1);

      for (int i = 0; i < 24; i++) begin
         logic        is_rd;
         logic [31:0] a;
         is_rd = 1'($urandom_range(0, 1));
         a     = 32'h200 + (32'($urandom_range(0, 7)) << 2);
         checked_op("rand", is_rd, !is_rd, a, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1);
      end

      checked_op("misaligned", 1'b1, 1'b0, 32'h103, 32'h0, 0, 0, 1'b1);
      checked_op("good_after_err", 1'b1, 1'b0, 32'h40, 32'h0, 0, 1, 1'b1);
      checked_op("rd_wr_conflict", 1'b1, 1'b1, 32'h200, 32'h5555_AAAA, 0, 0, 1'b1);
      checked_op("good_after_conflict", 1'b1, 1'b0, 32'h100, 32'h0, 2, 0, 1'b1);
      checked_op("timeout", 1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b0);

      @(negedge CLK);
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_rdata = 32'hDEAD_BEEF;
      @(negedge CLK);
      bus.mem_rsp_valid = 1'b0;
      #1;
      chk("stray_rsp_read_data", Read_data, last_rd);
      chk("stray_rsp_stall", 32'(Stall), 32'd0);
      chk("stray_rsp_req_valid", 32'(bus.mem_req_valid), 32'd0);

      access(1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b1, 1'b1);
      last_rd = 32'h0; err_exp = 1'b0;
      checked_op("load_after_reset", 1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the single-cycle core's data-memory port, taking the place of the zero-latency Data_memory.
- Converts each core load/store (Address, Write_data, MemRead, MemWrite) into a valid/ready request and response transaction on a slower external memory bus.
- Returns Read_data to the MemtoReg mux and drives a Stall output; the core holds PC and register write-enable while Stall is high.

Parameters:
- ADDR_W, 32, width of address on both sides.
- DATA_W, 32, width of data on both sides.
- TIMEOUT, 255, maximum cycles spent in REQ+RSP before the bridge aborts the access.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- MemRead  in  1  core load request (level, from Control).
- MemWrite  in  1  core store request (level, from Control).
- Address  in  ADDR_W  byte address (ALU_result).
- Write_data  in  DATA_W  store data (Read_data_2).
- Read_data  out  DATA_W  load data to MemtoReg mux.
- Stall  out  1  core must hold state this cycle.
- Mem_error  out  1  sticky error flag (misaligned, read+write conflict, timeout).
- mem_req_valid  out  1  request valid.
- mem_req_ready  in  1  external memory accepts request.
- mem_req_we  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_W  request address, bits [1:0] forced to 0.
- mem_req_wdata  out  DATA_W  write data.
- mem_rsp_valid  in  1  read data valid (single-cycle pulse).
- mem_rsp_rdata  in  DATA_W  read data.

Behaviour:
- Reset (async, active-high): state=IDLE, Read_data=0, Mem_error=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wdata=0, timeout counter=0.
- Access condition: acc = MemRead | MemWrite.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE, acc=0: Stall=0; remain in IDLE.
- IDLE, acc=1 and legal: Stall=1; register Address/Write_data/we into request regs; go to REQ.
- IDLE, acc=1 and illegal (Address[1:0]!=0, or MemRead&MemWrite): Stall=1; no bus request; set Mem_error; Read_data=0; go to DONE.
- REQ: mem_req_valid=1; request fields held stable until accepted; Stall=1.
  - Handshake occurs in the cycle where valid&ready are both high.
  - On handshake: write goes to DONE (writes are posted); read goes to RSP.
- RSP: Stall=1; wait for mem_rsp_valid; capture mem_rsp_rdata into Read_data; go to DONE.
- DONE: Stall=0 for exactly one cycle; the core commits at this edge; go to IDLE. Read_data holds its value until the next read capture.
- Minimum stall cycles: write 2 (ready high on first REQ cycle); read 3 (ready and rsp_valid each on first opportunity).
- Timeout: counter clears on entering REQ and increments each cycle in REQ/RSP.
  - When it reaches TIMEOUT: set Mem_error, Read_data=0, drop mem_req_valid, go to DONE.
  - A late mem_rsp_valid arriving in IDLE/DONE is ignored.
- mem_rsp_valid seen in IDLE, REQ or DONE: ignored; no state change.
- mem_req_valid is never deasserted in REQ before handshake (except on timeout or reset).
- Mem_error is cleared only by RESET.
- RESET mid-transaction: immediate return to IDLE; the outstanding external request is abandoned.
- Core inputs are not sampled in REQ/RSP/DONE; the core holds them stable while Stall=1.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding localparams: IDLE=2'd0, REQ=2'd1, RSP=2'd2, DONE=2'd3;
  - error read value 32'h0;
  - word-alignment mask 2'b11.
- One sub-module, bridge_timeout_cnt (clear, enable, TIMEOUT compare, expired output), is natural; everything else stays in data_mem_bridge.

Test Plan:
- Load, ready=1 immediately, rsp_valid on the cycle after handshake with rdata=32'h1234_5678 -> Stall high 3 cycles, Read_data=32'h1234_5678 in DONE, Mem_error=0.
- Store Address=32'h100, Write_data=32'hCAFE_F00D, ready held low 4 cycles -> mem_req_valid/addr/wdata/we stable throughout, Stall high 6 cycles total, DONE follows handshake.
- Load Address=32'h103 -> no mem_req_valid, Stall 1 cycle, Read_data=0, Mem_error=1 and stays 1 across later good accesses.
- MemRead=MemWrite=1 -> treated as illegal: Mem_error=1, no bus request.
- Load, ready=1, rsp_valid never asserted, TIMEOUT=8 -> DONE after 8 counted cycles, Read_data=0, Mem_error=1; a later stray rsp_valid in IDLE is ignored.
- RESET pulsed asynchronously while in RSP -> all outputs at reset values immediately (before next CLK edge); next load completes normally.
